room_manager: RTL and testbench
===============================

# room_manager

Room-transition controller that consumes the player's registered `doorcode` exit events and owns the current room index fed back to the player's collision lookup and to the background renderer. On an accepted exit it updates `room` from a fixed row-major map grid, marks the room visited, and runs a frame-paced fade-in ramp that the colour path uses to dim the screen. It sits between the player block and the level ROM and colour mapper, all clocked by the system clock with `frame_clk` as vertical-sync tick.

## Interface
- `MAP_COLS`, 4, rooms per map row
- `MAP_ROWS`, 2, map rows; `MAP_COLS*MAP_ROWS` ≤ 8
- `START_ROOM`, 0, room index after reset
- `FADE_STEP`, 1, `fade_level` increment per frame tick (1..15)
- `Clk`  in  1  system clock; all state on posedge
- `Reset`  in  1  synchronous, active-high
- `frame_clk`  in  1  frame tick (vsync); sampled in `Clk` domain
- `doorcode`  in  3  exit event: 0 none, 1 east, 2 west, 3 north, 4 south, 5–7 invalid
- `room`  out  3  current room index, row-major (`row*MAP_COLS+col`)
- `fade_level`  out  4  brightness, 0 black … 15 full
- `transition`  out  1  high while fade ramp is in progress
- `room_changed`  out  1  one-`Clk` pulse when `room` takes a new value
- `visited`  out  8  bit i set once room i has been entered

## Operation
- Frame tick: `frame_clk` registered once; tick = current high and delayed low.
- `armed` flag (internal): set when `doorcode`==0 is sampled; cleared on every accept. Prevents re-acceptance of a `doorcode` held for a whole frame.
- States: IDLE, FADE.
- IDLE: when `armed` and `doorcode` ∈ {1..4}: accept. Compute col = `room % MAP_COLS`, row = `room / MAP_COLS`.
  - 1 east: col+1; 2 west: col−1; 3 north: row−1; 4 south: row+1.
  - Target inside grid: `room` ← target, `visited[target]` ← 1, `room_changed` pulses, `fade_level` ← 0, `transition` ← 1, → FADE.
  - Target outside grid (no wrap): `room`, `fade_level` unchanged, no pulse, stay IDLE; `armed` still cleared.
- `doorcode` 5–7: ignored; does not arm or accept.
- FADE: each frame tick, `fade_level` ← min(15, `fade_level`+`FADE_STEP`) (5-bit add, saturate). On the tick that reaches 15: `transition` ← 0, → IDLE. Doorcodes ignored in FADE (`armed` still re-arms on 0).
- Accept and frame tick in same cycle: accept wins; that tick does not advance the ramp.
- Reset (any state, mid-fade included): `room`=`START_ROOM`, `fade_level`=15, `transition`=0, `room_changed`=0, `visited`=1<<`START_ROOM`, `armed`=1, state IDLE.

## Timing
- Accept latency: `doorcode` nonzero at posedge N → `room`, `room_changed`, `transition`, `fade_level`=0 valid after posedge N+1 (one `Clk`); player's collision lookup sees new room before its next frame update.
- `room_changed` high exactly one `Clk` cycle.
- Fade duration: ceil(15/`FADE_STEP`) frame ticks after accept; `FADE_STEP`=1 → 15 ticks, `FADE_STEP`=4 → 4 ticks (0,4,8,12,15).
- `room` stable throughout FADE.

## Configuration
- `ROOM_WRAP_EN` defined: out-of-grid targets wrap toroidally (col mod `MAP_COLS`, row mod `MAP_ROWS`); every valid exit changes room (unless grid dimension is 1) and starts a fade.
- Not defined: out-of-grid exits are discarded as above; player reappears in the same room.

## Test plan
- Reset then `doorcode`=1 for one frame from room 0 → one cycle later `room`=1, `room_changed` one-cycle pulse, `fade_level`=0, `transition`=1, `visited`=0x03.
- Continue frame ticks with `FADE_STEP`=1 → `fade_level` 1,2,…,15 on successive ticks; `transition` drops on 15th tick; `doorcode`=4 during ramp ignored (`room` stays 1).
- `doorcode`=4 held nonzero for 3 frames in IDLE from room 1 → `room`=5 once only; second exit accepted only after `doorcode` returns to 0.
- From room 3, `doorcode`=1: without `ROOM_WRAP_EN` → `room`=3, no pulse, `fade_level`=15; with it → `room`=0 and fade starts.
- `doorcode`=6 in IDLE → no change; `doorcode`=3 from room 0 without wrap → no change; with wrap → `room`=4.
- Assert `Reset` mid-fade at `fade_level`=7 in room 5 → next cycle `room`=0, `fade_level`=15, `transition`=0, `visited`=0x01.

Source files
------------

// File: rtl/room_manager.sv
// Room-transition controller: accepts armed door exits, steps the room index
// across a row-major map grid and runs a frame-paced fade-in ramp.
// Optional build macro ROOM_WRAP_EN: out-of-grid exits wrap toroidally instead of being discarded.
module room_manager #(
    parameter int MAP_COLS   = 4,
    parameter int MAP_ROWS   = 2,
    parameter int START_ROOM = 0,
    parameter int FADE_STEP  = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] doorcode,
    output logic [2:0] room,
    output logic [3:0] fade_level,
    output logic       transition,
    output logic       room_changed,
    output logic [7:0] visited
);

    typedef enum logic {IDLE, FADE} state_t;

    state_t     state, state_nxt;
    logic       frame_d, tick;
    logic       armed, armed_nxt;
    logic [2:0] room_nxt;
    logic [3:0] fade_nxt;
    logic       trans_nxt, changed_nxt;
    logic [7:0] visited_nxt;
    logic       target_ok;
    logic [2:0] target;
    logic [4:0] fade_sum;
    int         col, row;

    assign tick     = frame_clk & ~frame_d;
    assign fade_sum = {1'b0, fade_level} + 5'(FADE_STEP);

    always_comb begin
        col       = int'(room) % MAP_COLS;
        row       = int'(room) / MAP_COLS;
        target_ok = 1'b1;
        case (doorcode)
            3'd1:    col = col + 1;
            3'd2:    col = col - 1;
            3'd3:    row = row - 1;
            3'd4:    row = row + 1;
            default: target_ok = 1'b0;
        endcase
`ifdef ROOM_WRAP_EN
        col = (col + MAP_COLS) % MAP_COLS;
        row = (row + MAP_ROWS) % MAP_ROWS;
`else
        if (col < 0 || col >= MAP_COLS || row < 0 || row >= MAP_ROWS)
            target_ok = 1'b0;
`endif
        target = 3'(row * MAP_COLS + col);
    end

    always_comb begin
        state_nxt   = state;
        room_nxt    = room;
        fade_nxt    = fade_level;
        trans_nxt   = transition;
        changed_nxt = 1'b0;
        visited_nxt = visited;
        armed_nxt   = armed | (doorcode == 3'd0);
        case (state)
            IDLE: begin
                // A discarded (out-of-grid) exit still consumes the arm.
                if (armed && doorcode >= 3'd1 && doorcode <= 3'd4) begin
                    armed_nxt = 1'b0;
                    if (target_ok) begin
                        room_nxt            = target;
                        visited_nxt[target] = 1'b1;
                        changed_nxt         = 1'b1;
                        fade_nxt            = 4'd0;
                        trans_nxt           = 1'b1;
                        state_nxt           = FADE;
                    end
                end
            end
            FADE: begin
                if (tick) begin
                    if (fade_sum >= 5'd15) begin
                        fade_nxt  = 4'd15;
                        trans_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        fade_nxt = fade_sum[3:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            frame_d      <= 1'b0;
            armed        <= 1'b1;
            room         <= 3'(START_ROOM);
            fade_level   <= 4'd15;
            transition   <= 1'b0;
            room_changed <= 1'b0;
            visited      <= 8'd1 << START_ROOM;
        end else begin
            state        <= state_nxt;
            frame_d      <= frame_clk;
            armed        <= armed_nxt;
            room         <= room_nxt;
            fade_level   <= fade_nxt;
            transition   <= trans_nxt;
            room_changed <= changed_nxt;
            visited      <= visited_nxt;
        end
    end

endmodule

// File: tb/tb_room_manager.sv
// Directed bench for room_manager: expected output snapshots are queued when
// stimulus is driven and popped/compared once the DUT has produced its response.
module tb_room_manager;

    localparam int FADE_STEP = 1;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [2:0] doorcode;
    logic [2:0] room;
    logic [3:0] fade_level;
    logic       transition;
    logic       room_changed;
    logic [7:0] visited;

    room_manager #(
        .MAP_COLS(4), .MAP_ROWS(2), .START_ROOM(0), .FADE_STEP(FADE_STEP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .doorcode(doorcode),
        .room(room), .fade_level(fade_level), .transition(transition),
        .room_changed(room_changed), .visited(visited)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic [2:0] room;
        logic [3:0] fade;
        logic       trans;
        logic       rc;
        logic [7:0] vis;
    } exp_t;

    exp_t       sb[$];
    int         n_asserts = 0;
    int         n_fail = 0;
    logic [7:0] vis;
    logic [2:0] cur_room;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] r, input logic [3:0] f,
                        input logic t, input logic c, input logic [7:0] v);
        exp_t e;
        e.tag = tag; e.room = r; e.fade = f; e.trans = t; e.rc = c; e.vis = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".room"}, {5'd0, room}, {5'd0, e.room});
            cmp({e.tag, ".fade"}, {4'd0, fade_level}, {4'd0, e.fade});
            cmp({e.tag, ".transition"}, {7'd0, transition}, {7'd0, e.trans});
            cmp({e.tag, ".room_changed"}, {7'd0, room_changed}, {7'd0, e.rc});
            cmp({e.tag, ".visited"}, visited, e.vis);
        end
    endtask

    // Frame ticks while fading; doorcode = code for the first n_code ticks.
    task automatic run_ramp(input logic [2:0] code, input int n_code, input int max_ticks);
        int lvl = 0;
        for (int k = 1; k <= max_ticks; k++) begin
            doorcode  = (k <= n_code) ? code : 3'd0;
            frame_clk = 1'b1;
            step();
            frame_clk = 1'b0;
            lvl = (lvl + FADE_STEP > 15) ? 15 : lvl + FADE_STEP;
            push($sformatf("ramp_r%0d_t%0d", cur_room, k), cur_room, 4'(lvl), lvl != 15, 1'b0, vis);
            step();
            step();
            pop_check();
            if (lvl == 15) break;
        end
    endtask

    task automatic do_exit(input logic [2:0] code, input logic [2:0] exp_room,
                           input logic acc, input int ramp_ticks);
        doorcode = 3'd0;
        step();
        doorcode = code;
        if (acc) begin
            cur_room = exp_room;
            vis[exp_room] = 1'b1;
        end
        push($sformatf("exit%0d_to%0d", code, exp_room), cur_room, acc ? 4'd0 : 4'd15, acc, acc, vis);
        step();
        pop_check();
        doorcode = 3'd0;
        push($sformatf("exit%0d_after", code), cur_room, acc ? 4'd0 : 4'd15, acc, 1'b0, vis);
        step();
        pop_check();
        if (acc && ramp_ticks > 0) run_ramp(3'd0, 0, ramp_ticks);
    endtask

    initial begin
        Reset     = 1'b1;
        doorcode  = 3'd0;
        frame_clk = 1'b0;
        cur_room  = 3'd0;
        vis       = 8'h01;
        step();
        step();
        push("reset", 3'd0, 4'd15, 1'b0, 1'b0, 8'h01);
        pop_check();
        Reset = 1'b0;
        step();

        // East from room 0, code held; south requests during the ramp are ignored.
        doorcode = 3'd1;
        cur_room = 3'd1;
        vis      = 8'h03;
        push("east_accept", 3'd1, 4'd0, 1'b1, 1'b1, 8'h03);
        step();
        pop_check();
        push("east_pulse_end", 3'd1, 4'd0, 1'b1, 1'b0, 8'h03);
        step();
        pop_check();
        run_ramp(3'd4, 5, 20);

        // South held for the whole ramp and beyond: accepted exactly once.
        doorcode = 3'd4;
        cur_room = 3'd5;
        vis      = 8'h23;
        push("south_accept", 3'd5, 4'd0, 1'b1, 1'b1, 8'h23);
        step();
        pop_check();
        run_ramp(3'd4, 99, 20);
        doorcode = 3'd4;
        step();
        doorcode = 3'd1;
        push("held_not_armed", 3'd5, 4'd15, 1'b0, 1'b0, 8'h23);
        step();
        step();
        pop_check();

        do_exit(3'd1, 3'd6, 1'b1, 20);
        do_exit(3'd3, 3'd2, 1'b1, 20);
        do_exit(3'd1, 3'd3, 1'b1, 20);
`ifdef ROOM_WRAP_EN
        do_exit(3'd1, 3'd0, 1'b1, 20);
`else
        do_exit(3'd1, 3'd3, 1'b0, 0);
`endif
        do_exit(3'd6, cur_room, 1'b0, 0);
`ifndef ROOM_WRAP_EN
        do_exit(3'd2, 3'd2, 1'b1, 20);
        do_exit(3'd2, 3'd1, 1'b1, 20);
        do_exit(3'd2, 3'd0, 1'b1, 20);
`endif
`ifdef ROOM_WRAP_EN
        do_exit(3'd3, 3'd4, 1'b1, 20);
        do_exit(3'd1, 3'd5, 1'b1, 0);
`else
        do_exit(3'd3, 3'd0, 1'b0, 0);
        do_exit(3'd1, 3'd1, 1'b1, 20);
        do_exit(3'd4, 3'd5, 1'b1, 0);
`endif
        run_ramp(3'd0, 0, (7 + FADE_STEP - 1) / FADE_STEP);

        Reset = 1'b1;
        cur_room = 3'd0;
        vis      = 8'h01;
        push("reset_mid_fade", 3'd0, 4'd15, 1'b0, 1'b0, 8'h01);
        step();
        pop_check();
        Reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
